// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/funct inputs and datapath control outputs of the multicycle controller.
interface multicycle_control_if;
    logic [5:0] Opcode_i;
    logic [5:0] Funct_i;
    logic       IorD_o;
    logic       MemWrite_o;
    logic       IRWrite_o;
    logic       PCWrite_o;
    logic       Branch_o;
    logic [1:0] PCSrc_o;
    logic       ALUSrcA_o;
    logic [1:0] ALUSrcB_o;
    logic [1:0] ALUOp_o;
    logic [1:0] RegDst_o;
    logic [1:0] MemtoReg_o;
    logic       Reg_Write_o;
    modport master (
        input  Opcode_i, Funct_i,
        output IorD_o, MemWrite_o, IRWrite_o, PCWrite_o, Branch_o, PCSrc_o,
               ALUSrcA_o, ALUSrcB_o, ALUOp_o, RegDst_o, MemtoReg_o, Reg_Write_o
    );
    modport slave (
        output Opcode_i, Funct_i,
        input  IorD_o, MemWrite_o, IRWrite_o, PCWrite_o, Branch_o, PCSrc_o,
               ALUSrcA_o, ALUSrcB_o, ALUOp_o, RegDst_o, MemtoReg_o, Reg_Write_o
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing a multicycle MIPS datapath; optional jal via JAL_SUPPORT_EN.
module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_control_if.master ctl,
    output logic [STATE_W-1:0] State_o
);
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef JAL_SUPPORT_EN
    localparam logic [5:0] OP_JAL  = 6'b000011;
`endif

    typedef enum logic [STATE_W-1:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE,
        ALUWB, BRANCH, ADDIEX, IWB, JUMP
`ifdef JAL_SUPPORT_EN
        , JAL
`endif
    } state_t;

    state_t     state_q, state_d;
    logic       iord, mem_write, ir_write, pc_write, branch, alu_src_a, reg_write;
    logic [1:0] pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg;
    logic       unused_funct;

    assign unused_funct = ^ctl.Funct_i;

    always_ff @(posedge clk) begin
        state_q <= reset ? FETCH : state_d;
    end

    always_comb begin
        state_d    = FETCH;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        reg_write  = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
                state_d   = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (ctl.Opcode_i)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
`ifdef JAL_SUPPORT_EN
                    OP_JAL:       state_d = JAL;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (ctl.Opcode_i == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                iord    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                mem_to_reg = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_dst   = 2'b01;
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                branch    = 1'b1;
                pc_src    = 2'b01;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = IWB;
            end
            IWB: begin
                reg_write = 1'b1;
            end
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
`ifdef JAL_SUPPORT_EN
            JAL: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                reg_write  = 1'b1;
            end
`endif
            default: state_d = FETCH;
        endcase
    end

    // write enables are gated by reset so an abandoned instruction commits nothing
    assign ctl.MemWrite_o  = mem_write & ~reset;
    assign ctl.IRWrite_o   = ir_write & ~reset;
    assign ctl.PCWrite_o   = pc_write & ~reset;
    assign ctl.Branch_o    = branch & ~reset;
    assign ctl.Reg_Write_o = reg_write & ~reset;
    assign ctl.IorD_o      = iord;
    assign ctl.PCSrc_o     = pc_src;
    assign ctl.ALUSrcA_o   = alu_src_a;
    assign ctl.ALUSrcB_o   = alu_src_b;
    assign ctl.ALUOp_o     = alu_op;
    assign ctl.RegDst_o    = reg_dst;
    assign ctl.MemtoReg_o  = mem_to_reg;
    assign State_o         = state_q;
endmodule
